// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the elevator car controller slice.
package elevator_pkg;

  localparam int DEF_NUM_FLOORS = 7;
  localparam int DEF_FLOOR_W    = 3;

  typedef enum logic [1:0] {
    CAR_IDLE   = 2'd0,
    CAR_DECIDE = 2'd1,
    CAR_MOVING = 2'd2,
    CAR_DOOR   = 2'd3
  } car_state_t;

  typedef logic [DEF_FLOOR_W-1:0] floor_t;

endpackage

// File: rtl/elevator_car_controller_if.sv
// Signal bundle between the car controller, the call-button logic and the direction resolver.
interface elevator_car_controller_if
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
) ();

  logic                  req_valid;
  logic [FLOOR_W-1:0]    req_floor;
  logic                  next_up_ndown;
  logic                  queue_empty;
  logic [NUM_FLOORS-1:0] queue_status;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  current_up_ndown;
  logic                  door_open;
  logic                  moving;

  modport master (
    input  req_valid, req_floor, next_up_ndown, queue_empty,
    output queue_status, current_floor, current_up_ndown, door_open, moving
  );

  modport slave (
    output req_valid, req_floor, next_up_ndown, queue_empty,
    input  queue_status, current_floor, current_up_ndown, door_open, moving
  );

endinterface

// File: rtl/elevator_cycle_timer.sv
// Loadable down-counter; done is high once the count has reached zero.
module elevator_cycle_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  // Count register: load takes priority, otherwise decrement and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/elevator_car_controller.sv
// Car-side controller: latches floor calls and sequences stop decisions,
// timed floor-to-floor travel and timed door dwell.
module elevator_car_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
  parameter int FLOOR_W       = DEF_FLOOR_W,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input logic                       clk,
  input logic                       rst_n,
  elevator_car_controller_if.master bus
);

  localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TMR_W      = $clog2(MAX_CYCLES);
  localparam int FLOOR_W1   = FLOOR_W + 1;
  localparam logic [TMR_W-1:0]   TRAVEL_LOAD = TMR_W'(TRAVEL_CYCLES - 1);
  localparam logic [TMR_W-1:0]   DOOR_LOAD   = TMR_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W:0]   FLOOR_LIMIT = FLOOR_W1'(NUM_FLOORS);

  car_state_t            r_state;
  car_state_t            w_state_nxt;
  logic [NUM_FLOORS-1:0] r_queue;
  logic [NUM_FLOORS-1:0] w_set_mask;
  logic [NUM_FLOORS-1:0] w_clr_mask;
  logic [FLOOR_W-1:0]    r_floor;
  logic [FLOOR_W-1:0]    w_floor_nxt;
  logic                  r_up;
  logic                  w_up_nxt;
  logic                  w_tmr_load;
  logic [TMR_W-1:0]      w_tmr_val;
  logic                  w_tmr_done;
  logic                  w_req_in_range;
  logic                  w_req_here;

  assign w_req_in_range = bus.req_valid && ({1'b0, bus.req_floor} < FLOOR_LIMIT);
  // A call for the floor we are standing at is a stop, not a queue entry; once moving the car has left it.
  assign w_req_here     = w_req_in_range && (bus.req_floor == r_floor) && (r_state != CAR_MOVING);

  elevator_cycle_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  // Queue set mask from an accepted call button request.
  always_comb begin
    w_set_mask = '0;
    if (w_req_in_range && !w_req_here) begin
      w_set_mask[bus.req_floor] = 1'b1;
    end else begin
      w_set_mask = '0;
    end
  end

  // Next-state, timer load, queue clear and floor/direction updates.
  always_comb begin
    w_state_nxt = r_state;
    w_floor_nxt = r_floor;
    w_up_nxt    = r_up;
    w_clr_mask  = '0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    case (r_state)
      CAR_IDLE: begin
        if (w_req_here) begin
          w_tmr_load  = 1'b1;
          w_tmr_val   = DOOR_LOAD;
          w_state_nxt = CAR_DOOR;
        end else if (!bus.queue_empty) begin
          w_state_nxt = CAR_DECIDE;
        end else begin
          w_state_nxt = CAR_IDLE;
        end
      end
      CAR_DECIDE: begin
        if (r_queue[r_floor] || w_req_here) begin
          w_clr_mask[r_floor] = 1'b1;
          w_tmr_load          = 1'b1;
          w_tmr_val           = DOOR_LOAD;
          w_state_nxt         = CAR_DOOR;
        end else if (bus.queue_empty) begin
          w_state_nxt = CAR_IDLE;
        end else begin
          w_up_nxt    = bus.next_up_ndown;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TRAVEL_LOAD;
          w_state_nxt = CAR_MOVING;
        end
      end
      CAR_MOVING: begin
        if (w_tmr_done) begin
          w_state_nxt = CAR_DECIDE;
          // Clamp at the shaft ends: hold the floor, still re-decide.
          if (r_up && (r_floor != TOP_FLOOR)) begin
            w_floor_nxt = r_floor + FLOOR_W'(1);
          end else if (!r_up && (r_floor != '0)) begin
            w_floor_nxt = r_floor - FLOOR_W'(1);
          end else begin
            w_floor_nxt = r_floor;
          end
        end else begin
          w_state_nxt = CAR_MOVING;
        end
      end
      CAR_DOOR: begin
        if (w_req_here) begin
          w_tmr_load  = 1'b1;
          w_tmr_val   = DOOR_LOAD;
          w_state_nxt = CAR_DOOR;
        end else if (w_tmr_done) begin
          w_state_nxt = CAR_DECIDE;
        end else begin
          w_state_nxt = CAR_DOOR;
        end
      end
      default: begin
        w_state_nxt = CAR_IDLE;
      end
    endcase
  end

  // State, queue, floor and direction registers; clear beats set on the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CAR_IDLE;
      r_queue <= '0;
      r_floor <= '0;
      r_up    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_queue <= (r_queue | w_set_mask) & ~w_clr_mask;
      r_floor <= w_floor_nxt;
      r_up    <= w_up_nxt;
    end
  end

  assign bus.queue_status     = r_queue;
  assign bus.current_floor    = r_floor;
  assign bus.current_up_ndown = r_up;
  assign bus.door_open        = (r_state == CAR_DOOR);
  assign bus.moving           = (r_state == CAR_MOVING);

endmodule
